me_feeder: RTL and testbench

Source end of the motion-estimation row interface. Reads a current block and its 2N×2N search window from two synchronous RAMs, and emits the preload and stream beats that the PE row consumes on `c`, `p` and `p_prime`, with a one-cycle `start`. It then waits for the row's done, captures the best-match result, and reports it to the frame-level controller.

---
 rtl/me_pkg.sv | 24 ++
 rtl/me_feeder_if.sv | 44 ++++
 rtl/me_addr_gen.sv | 47 ++++
 rtl/me_feeder.sv | 170 +++++++++++++++++
 tb/tb_me_feeder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation feeder and its address generator.
package me_pkg;

  localparam int unsigned BLK_SIZE = 8;
  localparam int unsigned BS_SQ    = BLK_SIZE * BLK_SIZE;
  localparam int unsigned BS_CUBE  = BS_SQ * BLK_SIZE;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned ME_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    STREAM,
    DRAIN,
    DONE
  } me_state_e;

  typedef struct packed {
    logic [ME_W-1:0]  mme;
    logic [PIX_W-1:0] mi;
    logic [PIX_W-1:0] mj;
  } me_result_t;

endpackage

// File: rtl/me_feeder_if.sv
// RAM, PE-row and controller signals of me_feeder; master is the feeder, slave is its environment.
interface me_feeder_if #(
  parameter int unsigned BLK_SIZE = me_pkg::BLK_SIZE,
  parameter int unsigned ADDR_W   = $clog2(4 * BLK_SIZE * BLK_SIZE)
);
  import me_pkg::*;

  localparam int unsigned CUR_W = $clog2(BLK_SIZE * BLK_SIZE);

  logic              go;
  logic [CUR_W-1:0]  cur_addr;
  logic [PIX_W-1:0]  cur_rdata;
  logic [ADDR_W-1:0] pa_addr;
  logic [PIX_W-1:0]  pa_rdata;
  logic [ADDR_W-1:0] pb_addr;
  logic [PIX_W-1:0]  pb_rdata;
  logic [PIX_W-1:0]  c;
  logic [PIX_W-1:0]  p;
  logic [PIX_W-1:0]  p_prime;
  logic              start;
  logic              pe_done;
  logic [ME_W-1:0]   pe_mme;
  logic [PIX_W-1:0]  pe_mi;
  logic [PIX_W-1:0]  pe_mj;
  logic              busy;
  logic [ME_W-1:0]   res_mme;
  logic [PIX_W-1:0]  res_mi;
  logic [PIX_W-1:0]  res_mj;
  logic              res_valid;
  logic              res_err;

  modport master (
    input  go, cur_rdata, pa_rdata, pb_rdata, pe_done, pe_mme, pe_mi, pe_mj,
    output cur_addr, pa_addr, pb_addr, c, p, p_prime, start, busy,
           res_mme, res_mi, res_mj, res_valid, res_err
  );

  modport slave (
    output go, cur_rdata, pa_rdata, pb_rdata, pe_done, pe_mme, pe_mi, pe_mj,
    input  cur_addr, pa_addr, pb_addr, c, p, p_prime, start, busy,
           res_mme, res_mi, res_mj, res_valid, res_err
  );

endinterface

// File: rtl/me_addr_gen.sv
// Combinational address generator: maps phase and beat index to current-block and search RAM addresses.
module me_addr_gen #(
  parameter int unsigned BLK_SIZE = 8,
  parameter int unsigned SW       = 2 * BLK_SIZE,
  parameter int unsigned ADDR_W   = $clog2(4 * BLK_SIZE * BLK_SIZE)
) (
  input  me_pkg::me_state_e              phase,
  input  logic [3*$clog2(BLK_SIZE)-1:0]  beat,
  output logic [2*$clog2(BLK_SIZE)-1:0]  cur_addr,
  output logic [ADDR_W-1:0]              pa_addr,
  output logic [ADDR_W-1:0]              pb_addr
);
  import me_pkg::*;

  localparam int unsigned LOG_N = $clog2(BLK_SIZE);
  localparam int unsigned CUR_W = 2 * LOG_N;

  logic [LOG_N-1:0]  mi;
  logic [LOG_N-1:0]  r;
  logic [LOG_N-1:0]  col;
  logic [ADDR_W-1:0] row_b;

  // N is a power of two, so the beat splits into candidate row, block row and column by bit slices
  assign col = beat[LOG_N-1:0];
  assign r   = beat[2*LOG_N-1:LOG_N];
  assign mi  = beat[3*LOG_N-1:2*LOG_N];

  always_comb begin
    cur_addr = '0;
    pa_addr  = '0;
    pb_addr  = '0;
    row_b    = ADDR_W'(mi) + ADDR_W'(r);
    case (phase)
      PRELOAD: begin
        pb_addr = ADDR_W'(col);
        pa_addr = ADDR_W'(SW) + ADDR_W'(col);
      end
      STREAM: begin
        cur_addr = beat[CUR_W-1:0];
        pb_addr  = row_b * ADDR_W'(SW) + ADDR_W'(col) + ADDR_W'(BLK_SIZE);
        pa_addr  = (row_b + ADDR_W'(1)) * ADDR_W'(SW) + ADDR_W'(col) + ADDR_W'(BLK_SIZE);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/me_feeder.sv
// Feeds preload and stream beats from the block/search RAMs to the ME PE row and captures its result.
// Optional DRAIN timeout with res_err reporting: define ME_FEEDER_TIMEOUT_EN.
module me_feeder #(
  parameter int unsigned BLK_SIZE  = me_pkg::BLK_SIZE,
  parameter int unsigned SW        = 2 * BLK_SIZE,
  parameter int unsigned ADDR_W    = $clog2(4 * BLK_SIZE * BLK_SIZE),
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  me_feeder_if.master bus
);
  import me_pkg::*;

  localparam int unsigned LOG_N  = $clog2(BLK_SIZE);
  localparam int unsigned CUR_W  = 2 * LOG_N;
  localparam int unsigned BEAT_W = 3 * LOG_N;
  localparam int unsigned N_CUBE = BLK_SIZE * BLK_SIZE * BLK_SIZE;
  localparam int unsigned DRN_W  = $clog2(DRAIN_MAX);
  localparam int unsigned T_W    = (BEAT_W > DRN_W) ? BEAT_W : DRN_W;

  me_state_e         state, state_nx;
  logic [T_W-1:0]    t, t_nx;
  logic              capture_c;
  logic [CUR_W-1:0]  cur_a_c;
  logic [ADDR_W-1:0] pa_a_c;
  logic [ADDR_W-1:0] pb_a_c;
  logic              s1_vld, s1_pre, s1_first;
  logic              s2_vld, s2_pre, s2_first;
  me_result_t        res_q;
`ifdef ME_FEEDER_TIMEOUT_EN
  logic              timeout_c;
  logic              err_q;
`endif

  // Next-state and beat counter
  always_comb begin
    state_nx  = state;
    t_nx      = t;
    capture_c = 1'b0;
`ifdef ME_FEEDER_TIMEOUT_EN
    timeout_c = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.go) begin
          state_nx = PRELOAD;
          t_nx     = '0;
        end
      end
      PRELOAD: begin
        if (t == T_W'(BLK_SIZE - 1)) begin
          state_nx = STREAM;
          t_nx     = '0;
        end else begin
          t_nx = t + T_W'(1);
        end
      end
      STREAM: begin
        if (t == T_W'(N_CUBE - 1)) begin
          state_nx = DRAIN;
          t_nx     = '0;
        end else begin
          t_nx = t + T_W'(1);
        end
      end
      DRAIN: begin
        if (bus.pe_done) begin
          capture_c = 1'b1;
          state_nx  = DONE;
        end
`ifdef ME_FEEDER_TIMEOUT_EN
        else if (t == T_W'(DRAIN_MAX - 1)) begin
          timeout_c = 1'b1;
          state_nx  = DONE;
        end else begin
          t_nx = t + T_W'(1);
        end
`endif
      end
      DONE: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
    endcase
  end

  // Addresses are decoded from the next phase/beat so the registered address lines up with the state
  me_addr_gen #(
    .BLK_SIZE (BLK_SIZE),
    .SW       (SW),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .phase    (state_nx),
    .beat     (t_nx[BEAT_W-1:0]),
    .cur_addr (cur_a_c),
    .pa_addr  (pa_a_c),
    .pb_addr  (pb_a_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      t             <= '0;
      bus.cur_addr  <= '0;
      bus.pa_addr   <= '0;
      bus.pb_addr   <= '0;
      s1_vld        <= 1'b0;
      s1_pre        <= 1'b0;
      s1_first      <= 1'b0;
      s2_vld        <= 1'b0;
      s2_pre        <= 1'b0;
      s2_first      <= 1'b0;
      bus.c         <= '0;
      bus.p         <= '0;
      bus.p_prime   <= '0;
      bus.start     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      res_q         <= '0;
    end else begin
      state        <= state_nx;
      t            <= t_nx;
      bus.cur_addr <= cur_a_c;
      bus.pa_addr  <= pa_a_c;
      bus.pb_addr  <= pb_a_c;
      // Beat tags travel alongside the two-cycle address-to-output latency
      s1_vld       <= (state_nx == PRELOAD) || (state_nx == STREAM);
      s1_pre       <= (state_nx == PRELOAD);
      s1_first     <= (state_nx == PRELOAD) && (t_nx == '0);
      s2_vld       <= s1_vld;
      s2_pre       <= s1_pre;
      s2_first     <= s1_first;
      bus.c        <= (s2_vld && !s2_pre) ? bus.cur_rdata : '0;
      bus.p        <= s2_vld ? bus.pa_rdata : '0;
      bus.p_prime  <= s2_vld ? bus.pb_rdata : '0;
      bus.start    <= s2_first;
      bus.busy     <= (state_nx != IDLE);
      bus.res_valid <= capture_c;
      if (capture_c) begin
        res_q <= {bus.pe_mme, bus.pe_mi, bus.pe_mj};
      end
    end
  end

  assign bus.res_mme = res_q.mme;
  assign bus.res_mi  = res_q.mi;
  assign bus.res_mj  = res_q.mj;

`ifdef ME_FEEDER_TIMEOUT_EN
  // Sticky timeout flag, cleared when the next run is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && bus.go) begin
      err_q <= 1'b0;
    end else if (timeout_c) begin
      err_q <= 1'b1;
    end
  end
  assign bus.res_err = err_q;
`else
  assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_me_feeder.sv
// Directed bench for me_feeder: N=8, search[a]=a, cur[a]=a; cycle k counts from the cycle go is sampled.
module tb_me_feeder;
  import me_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   bad;

  always #5 clk = ~clk;

  me_feeder_if #(.BLK_SIZE(8)) bus ();

  me_feeder #(
    .BLK_SIZE  (8),
    .DRAIN_MAX (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous RAMs with identity contents
  always @(posedge clk) begin
    bus.cur_rdata <= 8'(bus.cur_addr);
    bus.pa_rdata  <= bus.pa_addr;
    bus.pb_rdata  <= bus.pb_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.go      = 1'b0;
    bus.pe_done = 1'b0;
    bus.pe_mme  = '0;
    bus.pe_mi   = '0;
    bus.pe_mj   = '0;

    // Reset state
    step(3);
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_addrs", {bus.cur_addr, bus.pa_addr, bus.pb_addr}, 0);
    chk("rst_beats", {bus.c, bus.p, bus.p_prime}, 0);
    chk("rst_res", {bus.res_mme, bus.res_mi, bus.res_mj}, 0);
    chk("rst_flags", {bus.res_valid, bus.res_err}, 0);
    bad = 0;
    repeat (20) begin
      step(1);
      if (bus.start !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("rst_quiet20", bad, 0);

    // Full run
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
    chk("c1_busy", bus.busy, 1);
    chk("c1_addrs", {bus.cur_addr, bus.pa_addr, bus.pb_addr}, {6'd0, 8'd16, 8'd0});
    step(2);
    chk("c3_start", bus.start, 1);
    chk("c3_beat", {bus.c, bus.p, bus.p_prime}, {8'd0, 8'd16, 8'd0});
    step(1);
    chk("c4_start", bus.start, 0);
    chk("c4_beat", {bus.c, bus.p, bus.p_prime}, {8'd0, 8'd17, 8'd1});
    step(7);
    chk("c11_beat", {bus.c, bus.p, bus.p_prime}, {8'd0, 8'd24, 8'd8});
    step(1);
    chk("c12_beat", {bus.c, bus.p, bus.p_prime}, {8'd1, 8'd25, 8'd9});
    // pe_done outside DRAIN must be ignored
    step(28);
    bus.pe_done = 1'b1;
    bus.pe_mme  = 16'hBEEF;
    bus.pe_mi   = 8'd9;
    bus.pe_mj   = 8'd9;
    step(1);
    bus.pe_done = 1'b0;
    chk("c41_no_valid", bus.res_valid, 0);
    chk("c41_beat", {bus.c, bus.p, bus.p_prime}, {8'd30, 8'd78, 8'd62});

    // go while busy has no effect
    step(59);
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
    chk("c101_busy", bus.busy, 1);
    step(199);
    chk("c300_beat", {bus.c, bus.p, bus.p_prime}, {8'd33, 8'd153, 8'd137});
    chk("c300_res_held", bus.res_mme, 0);
    step(220);
    chk("c520_addrs", {bus.cur_addr, bus.pa_addr, bus.pb_addr}, {6'd63, 8'd255, 8'd239});
    step(1);
    chk("c521_drain_addr", {bus.cur_addr, bus.pa_addr, bus.pb_addr}, 0);
    chk("c521_busy", bus.busy, 1);
    step(1);
    chk("c522_beat", {bus.c, bus.p, bus.p_prime}, {8'd63, 8'd255, 8'd239});

    // Result capture
    step(3);
    chk("c525_busy", bus.busy, 1);
    chk("c525_no_valid", bus.res_valid, 0);
    bus.pe_done = 1'b1;
    bus.pe_mme  = 16'h0123;
    bus.pe_mi   = 8'd2;
    bus.pe_mj   = 8'hFD;
    step(1);
    bus.pe_done = 1'b0;
    chk("cap_valid", bus.res_valid, 1);
    chk("cap_res", {bus.res_mme, bus.res_mi, bus.res_mj}, {16'h0123, 8'd2, 8'hFD});
    chk("cap_busy_done", bus.busy, 1);
    step(1);
    chk("cap_valid_drop", bus.res_valid, 0);
    chk("cap_busy_drop", bus.busy, 0);
    chk("cap_res_hold", {bus.res_mme, bus.res_mi, bus.res_mj}, {16'h0123, 8'd2, 8'hFD});

`ifdef ME_FEEDER_TIMEOUT_EN
    // DRAIN timeout without pe_done
    step(2);
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
    step(520);
    chk("to_drain_busy", bus.busy, 1);
    step(63);
    chk("to_c584_busy", bus.busy, 1);
    chk("to_c584_err", bus.res_err, 0);
    step(1);
    chk("to_err_set", bus.res_err, 1);
    chk("to_res_kept", {bus.res_mme, bus.res_mi, bus.res_mj}, {16'h0123, 8'd2, 8'hFD});
    step(1);
    chk("to_idle", bus.busy, 0);
    chk("to_err_hold", bus.res_err, 1);
`endif

    // Mid-run reset at STREAM beat 200
    step(2);
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
`ifdef ME_FEEDER_TIMEOUT_EN
    chk("to_err_clear", bus.res_err, 0);
`endif
    step(208);
    chk("mr_beat200_addr", bus.cur_addr, 8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_addrs", {bus.cur_addr, bus.pa_addr, bus.pb_addr}, 0);
    chk("mr_beats", {bus.c, bus.p, bus.p_prime, 7'd0, bus.start}, 0);
    chk("mr_res", {bus.res_mme, bus.res_valid}, 0);
    bad = 0;
    bus.pe_done = 1'b1;
    repeat (40) begin
      step(1);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.start !== 1'b0) bad++;
    end
    bus.pe_done = 1'b0;
    chk("mr_quiet40", bad, 0);

    // Fresh run after abort keeps the standard timing
    bus.go = 1'b1;
    step(1);
    bus.go = 1'b0;
    step(2);
    chk("fr_c3_start", bus.start, 1);
    chk("fr_c3_beat", {bus.c, bus.p, bus.p_prime}, {8'd0, 8'd16, 8'd0});
    step(8);
    chk("fr_c11_beat", {bus.c, bus.p, bus.p_prime}, {8'd0, 8'd24, 8'd8});
    step(511);
    chk("fr_c522_beat", {bus.c, bus.p, bus.p_prime}, {8'd63, 8'd255, 8'd239});
    step(3);
    bus.pe_done = 1'b1;
    bus.pe_mme  = 16'h4567;
    bus.pe_mi   = 8'd1;
    bus.pe_mj   = 8'd3;
    step(1);
    bus.pe_done = 1'b0;
    chk("fr_cap_valid", bus.res_valid, 1);
    chk("fr_cap_res", {bus.res_mme, bus.res_mi, bus.res_mj}, {16'h4567, 8'd1, 8'd3});
`ifndef ME_FEEDER_TIMEOUT_EN
    chk("no_to_err", bus.res_err, 0);
`endif
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
